// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: datapath width, reset PC, PC step and
// the fetch sequencer state encoding.
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_STEP  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/next_pc_mux.sv
// Next fetch address select: sequential PC+4 (modulo 2^XLEN) or the branch
// target with its low two bits forced to zero.
// Ports:
//   pc_i         current fetch address
//   target_i     raw branch target from the shift-adder
//   sel_target_i 1 selects the aligned target, 0 selects pc_i + PC_STEP
//   next_pc_c_o  combinational next address
module next_pc_mux #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            sel_target_i,
  output logic [XLEN-1:0] next_pc_c_o
);
  import riscv_pkg::*;

  // Word alignment mask: clears the two byte-offset bits of the target.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  always_comb begin
    if (sel_target_i) begin
      next_pc_c_o = target_i & ALIGN_MASK;
    end else begin
      next_pc_c_o = pc_i + XLEN'(PC_STEP);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction fetch sequencer. Issues req/ack
// fetches to instruction memory, hands {pc_out, instr_valid} to decode,
// honours decode stall and redirects on taken branches with a flush pulse.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   imem_req/addr      fetch request and address (addr stable until ack)
//   imem_ack           memory accepted the request this cycle
//   stall              decode cannot accept a new instruction
//   br_valid/branch/zero/branch_target  resolved branch from EX
//   pc_out/instr_valid PC of instruction presented to decode
//   flush              one-cycle pulse discarding younger pipeline contents
module pc_sequencer #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h0000_0000)
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            branch,
  input  logic            zero,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid,
  output logic            flush
);
  import riscv_pkg::*;

  fsm_state_e      state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            flush_q, flush_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            taken_c;
  logic [XLEN-1:0] next_pc_c;

  assign taken_c = br_valid & branch & zero;

  // On a taken branch the mux yields the aligned target, otherwise addr+4.
  next_pc_mux #(
    .XLEN (XLEN)
  ) u_next_pc_mux (
    .pc_i         (addr_q),
    .target_i     (branch_target),
    .sel_target_i (taken_c),
    .next_pc_c_o  (next_pc_c)
  );

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
      pend_q   <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      flush_q  <= flush_d;
      pend_q   <= pend_d;
      target_q <= target_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    flush_d  = 1'b0;
    pend_d   = pend_q;
    target_d = target_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = RESET_PC;
      end

      FETCH: begin
        if (taken_c) begin
          flush_d = 1'b1;
          valid_d = 1'b0;
          if (req_q && !imem_ack) begin
            // Request in flight: address must stay put, so park the target.
            pend_d   = 1'b1;
            target_d = next_pc_c;
          end else begin
            // Any instruction acked this cycle is wrong-path and dropped.
            addr_d = next_pc_c;
            req_d  = 1'b1;
            pend_d = 1'b0;
          end
        end else if (req_q && imem_ack) begin
          if (pend_q) begin
            addr_d  = target_q;
            pend_d  = 1'b0;
            valid_d = 1'b0;
          end else begin
            pc_d    = addr_q;
            valid_d = 1'b1;
            addr_d  = next_pc_c;
            if (stall) begin
              state_d = HOLD;
              req_d   = 1'b0;
            end
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (taken_c) begin
          // Redirect overrides the stall and kills the held instruction.
          flush_d = 1'b1;
          valid_d = 1'b0;
          addr_d  = next_pc_c;
          req_d   = 1'b1;
          state_d = FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign pc_out      = pc_q;
  assign instr_valid = valid_q;
  assign flush       = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, delayed ack, taken
// branches with and without an outstanding request, stall/HOLD, PC wrap
// and mid-fetch reset.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        stall;
  logic        br_valid;
  logic        branch;
  logic        zero;
  logic [31:0] branch_target;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        flush;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  pc_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .stall         (stall),
    .br_valid      (br_valid),
    .branch        (branch),
    .zero          (zero),
    .branch_target (branch_target),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .flush         (flush)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_branch(input logic bv, input logic br, input logic z, input logic [31:0] tgt);
    br_valid      = bv;
    branch        = br;
    zero          = z;
    branch_target = tgt;
  endtask

  // Reset for two cycles, release, then step past IDLE into FETCH at addr 0.
  task automatic apply_reset(input logic ack);
    reset    = 1'b1;
    imem_ack = ack;
    stall    = 1'b0;
    set_branch(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    imem_ack = 1'b0;
    stall    = 1'b0;
    set_branch(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    tests_run++;
    if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    tests_run++;
    if (pc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    tests_run++;
    if (instr_valid !== 1'b0 || flush !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid_flush got=%b%b exp=00", instr_valid, flush);
    end
  endtask

  task automatic test_sequential();
    imem_ack = 1'b1;
    reset    = 1'b0;
    step();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL seq_first got req=%b addr=%h v=%b exp req=1 addr=0 v=0", imem_req, imem_addr, instr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (pc_out !== 32'(i * 4) || instr_valid !== 1'b1 || imem_addr !== 32'((i + 1) * 4)) begin
        tests_failed++;
        $display("FAIL seq_%0d got pc=%h v=%b addr=%h exp pc=%h v=1 addr=%h",
                 i, pc_out, instr_valid, imem_addr, 32'(i * 4), 32'((i + 1) * 4));
      end
    end
  endtask

  task automatic test_ack_delay();
    apply_reset(1'b1);
    step();
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL ackwait_%0d got req=%b addr=%h v=%b exp req=1 addr=8 v=0", i, imem_req, imem_addr, instr_valid);
      end
    end
    imem_ack = 1'b1;
    step();
    tests_run++;
    if (pc_out !== 32'h8 || instr_valid !== 1'b1 || imem_addr !== 32'hC) begin
      tests_failed++;
      $display("FAIL ackwait_done got pc=%h v=%b addr=%h exp pc=8 v=1 addr=c", pc_out, instr_valid, imem_addr);
    end
  endtask

  task automatic test_taken_no_outstanding();
    set_branch(1'b1, 1'b1, 1'b1, 32'h40);
    step();
    tests_run++;
    if (flush !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL t3_redirect got fl=%b v=%b addr=%h req=%b exp fl=1 v=0 addr=40 req=1", flush, instr_valid, imem_addr, imem_req);
    end
    set_branch(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    tests_run++;
    if (flush !== 1'b0 || pc_out !== 32'h40 || instr_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL t3_target got fl=%b pc=%h v=%b exp fl=0 pc=40 v=1", flush, pc_out, instr_valid);
    end
    set_branch(1'b1, 1'b1, 1'b0, 32'h200);
    step();
    tests_run++;
    if (flush !== 1'b0 || pc_out !== 32'h44 || imem_addr !== 32'h48) begin
      tests_failed++;
      $display("FAIL t3_notaken_zero got fl=%b pc=%h addr=%h exp fl=0 pc=44 addr=48", flush, pc_out, imem_addr);
    end
    set_branch(1'b1, 1'b0, 1'b1, 32'h200);
    step();
    tests_run++;
    if (flush !== 1'b0 || pc_out !== 32'h48 || imem_addr !== 32'h4C) begin
      tests_failed++;
      $display("FAIL t3_notaken_branch got fl=%b pc=%h addr=%h exp fl=0 pc=48 addr=4c", flush, pc_out, imem_addr);
    end
    set_branch(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_taken_outstanding();
    apply_reset(1'b1);
    for (int i = 0; i < 4; i++) step();
    imem_ack = 1'b0;
    set_branch(1'b1, 1'b1, 1'b1, 32'h80);
    step();
    tests_run++;
    if (flush !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h10 || imem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL t4_pend got fl=%b v=%b addr=%h req=%b exp fl=1 v=0 addr=10 req=1", flush, instr_valid, imem_addr, imem_req);
    end
    set_branch(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    tests_run++;
    if (flush !== 1'b0 || imem_addr !== 32'h10) begin
      tests_failed++; $display("FAIL t4_hold got fl=%b addr=%h exp fl=0 addr=10", flush, imem_addr);
    end
    imem_ack = 1'b1;
    step();
    tests_run++;
    if (imem_addr !== 32'h80 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL t4_drop got addr=%h v=%b exp addr=80 v=0", imem_addr, instr_valid);
    end
    step();
    tests_run++;
    if (pc_out !== 32'h80 || instr_valid !== 1'b1 || imem_addr !== 32'h84) begin
      tests_failed++; $display("FAIL t4_fetch got pc=%h v=%b addr=%h exp pc=80 v=1 addr=84", pc_out, instr_valid, imem_addr);
    end
    set_branch(1'b1, 1'b1, 1'b1, 32'h83);
    step();
    tests_run++;
    if (imem_addr !== 32'h80 || flush !== 1'b1 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL t4_align got addr=%h fl=%b v=%b exp addr=80 fl=1 v=0", imem_addr, flush, instr_valid);
    end
    imem_ack = 1'b0;
    set_branch(1'b1, 1'b1, 1'b1, 32'h100);
    step();
    set_branch(1'b1, 1'b1, 1'b1, 32'h200);
    step();
    tests_run++;
    if (imem_addr !== 32'h80 || flush !== 1'b1) begin
      tests_failed++; $display("FAIL t4_second got addr=%h fl=%b exp addr=80 fl=1", imem_addr, flush);
    end
    set_branch(1'b0, 1'b0, 1'b0, 32'h0);
    imem_ack = 1'b1;
    step();
    tests_run++;
    if (imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL t4_overwrite got addr=%h v=%b exp addr=200 v=0", imem_addr, instr_valid);
    end
  endtask

  task automatic test_stall();
    apply_reset(1'b1);
    for (int i = 0; i < 5; i++) step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (imem_req !== 1'b0 || pc_out !== 32'h14 || instr_valid !== 1'b1 || imem_addr !== 32'h18) begin
        tests_failed++;
        $display("FAIL t5_hold_%0d got req=%b pc=%h v=%b addr=%h exp req=0 pc=14 v=1 addr=18",
                 i, imem_req, pc_out, instr_valid, imem_addr);
      end
    end
    set_branch(1'b1, 1'b1, 1'b1, 32'h60);
    step();
    tests_run++;
    if (flush !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h60 || imem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL t5_redirect got fl=%b v=%b addr=%h req=%b exp fl=1 v=0 addr=60 req=1", flush, instr_valid, imem_addr, imem_req);
    end
    set_branch(1'b0, 1'b0, 1'b0, 32'h0);
    stall = 1'b0;
    step();
    tests_run++;
    if (flush !== 1'b0 || pc_out !== 32'h60 || instr_valid !== 1'b1 || imem_addr !== 32'h64) begin
      tests_failed++;
      $display("FAIL t5_resume got fl=%b pc=%h v=%b addr=%h exp fl=0 pc=60 v=1 addr=64", flush, pc_out, instr_valid, imem_addr);
    end
  endtask

  task automatic test_wrap_and_reset();
    imem_ack = 1'b1;
    set_branch(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step();
    set_branch(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    tests_run++;
    if (pc_out !== 32'hFFFF_FFFC || instr_valid !== 1'b1 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL t6_wrap got pc=%h v=%b addr=%h exp pc=fffffffc v=1 addr=0", pc_out, instr_valid, imem_addr);
    end
    imem_ack = 1'b0;
    reset    = 1'b1;
    step();
    tests_run++;
    if (imem_req !== 1'b0 || pc_out !== 32'h0 || instr_valid !== 1'b0 || flush !== 1'b0 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL t6_reset got req=%b pc=%h v=%b fl=%b addr=%h exp all zero",
               imem_req, pc_out, instr_valid, flush, imem_addr);
    end
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ack_delay();
    test_taken_no_outstanding();
    test_taken_outstanding();
    test_stall();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
